// File: rtl/gpio_btn_reader.sv
// gpio_btn_reader: synchronises and debounces one raw pin into a clean level, rise/fall pulses and a press counter.
// Define LONG_PRESS_EN to build the long-hold pulse; otherwise long_press is tied low.
module gpio_btn_reader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 8,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GPIO_IN,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] press_cnt,
    output logic             long_press
);
    localparam int   DW    = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic INACT = (ACTIVE_LOW != 0);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2) begin : g_bad_param
        $error("gpio_btn_reader: DEBOUNCE_CYCLES must be >= 1 and LONG_CYCLES >= 2");
    end

    typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

    state_t          state, nxt;
    logic            ff1, ff2, s, done, acc_hi, acc_lo;
    logic [DW-1:0]   dcnt, dcnt_nxt;

    assign s    = ff2 ^ INACT;
    assign done = dcnt == DW'(DEBOUNCE_CYCLES - 1);

    // sync FFs reset to the inactive pin value so no edge is seen right after reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            ff1   <= INACT;
            ff2   <= INACT;
            state <= IDLE_LO;
            dcnt  <= '0;
        end else begin
            ff1   <= GPIO_IN;
            ff2   <= ff1;
            state <= nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    always_comb begin
        nxt      = state;
        dcnt_nxt = dcnt;
        case (state)
            IDLE_LO: if (s) begin
                nxt      = WAIT_HI;
                dcnt_nxt = '0;
            end
            WAIT_HI: if (!s) nxt = IDLE_LO;
                     else if (done) nxt = IDLE_HI;
                     else dcnt_nxt = dcnt + 1'b1;
            IDLE_HI: if (!s) begin
                nxt      = WAIT_LO;
                dcnt_nxt = '0;
            end
            WAIT_LO: if (s) nxt = IDLE_HI;
                     else if (done) nxt = IDLE_LO;
                     else dcnt_nxt = dcnt + 1'b1;
            default: nxt = IDLE_LO;
        endcase
    end

    always_comb begin
        acc_hi = state == WAIT_HI && s && done;
        acc_lo = state == WAIT_LO && !s && done;
        level  = state == IDLE_HI || state == WAIT_LO;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rise      <= 1'b0;
            fall      <= 1'b0;
            press_cnt <= '0;
        end else begin
            rise      <= acc_hi;
            fall      <= acc_lo;
            press_cnt <= clr_cnt ? '0 : acc_hi ? press_cnt + 1'b1 : press_cnt;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES);

    logic [HW-1:0] hcnt;

    // saturating at LONG_CYCLES-1 makes the pulse one-shot until the next accepted rise
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= state == IDLE_HI && hcnt == HW'(LONG_CYCLES - 2);
            if (acc_hi) hcnt <= '0;
            else if (state == IDLE_HI && hcnt != HW'(LONG_CYCLES - 1)) hcnt <= hcnt + 1'b1;
        end
    end
`else
    assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_btn_reader.sv
// tb_gpio_btn_reader: directed stimulus against a run-length debounce model, plus literal timing checks.
module tb_gpio_btn_reader;
    localparam int D = 4;
    localparam int W = 3;
    localparam int L = 10;
`ifdef LONG_PRESS_EN
    localparam int LP = 1;
`else
    localparam int LP = 0;
`endif

    logic         CLK = 0, RST = 1, GPIO_IN = 1, clr_cnt = 0;
    logic         level, rise, fall, long_press;
    logic [W-1:0] press_cnt;

    int checks = 0, fails = 0;
    int n_rise = 0, n_fall = 0, n_long = 0;
    int r0, f0, l0;
    bit started = 0;

    logic [1:0]   pipe = 2'b11;
    logic         e_level = 0, e_rise = 0, e_fall = 0, e_long = 0;
    logic [W-1:0] e_cnt = 0;
    int           run = 0, hold = 0;

    gpio_btn_reader #(.DEBOUNCE_CYCLES(D), .CNT_W(W), .ACTIVE_LOW(1), .LONG_CYCLES(L)) dut (
        .CLK(CLK), .RST(RST), .GPIO_IN(GPIO_IN), .clr_cnt(clr_cnt),
        .level(level), .rise(rise), .fall(fall), .press_cnt(press_cnt), .long_press(long_press)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // model: a new level is accepted once D+1 consecutive synchronised samples disagree with it
    always @(posedge CLK) begin
        logic s, ih;
        started = 1;
        if (RST) begin
            pipe = 2'b11; e_level = 0; e_rise = 0; e_fall = 0; e_long = 0;
            e_cnt = '0; run = 0; hold = 0;
        end else begin
            s  = pipe[1] ^ 1'b1;
            ih = e_level && run == 0;
            pipe = {pipe[0], GPIO_IN};
            e_rise = 0; e_fall = 0; e_long = 0;
            run = (s != e_level) ? run + 1 : 0;
            if (run == D + 1) begin
                e_level = !e_level;
                e_rise  = e_level;
                e_fall  = !e_level;
                run     = 0;
            end
            e_cnt = clr_cnt ? '0 : e_cnt + W'(e_rise);
`ifdef LONG_PRESS_EN
            if (e_rise) hold = 0;
            else if (ih) begin
                e_long = (hold == L - 2);
                if (hold < L - 1) hold++;
            end
`endif
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("level", level, e_level);
            chk("rise", rise, e_rise);
            chk("fall", fall, e_fall);
            chk("press_cnt", press_cnt, e_cnt);
            chk("long_press", long_press, e_long);
            chk("rise_fall_excl", rise & fall, 0);
            n_rise += (rise === 1'b1);
            n_fall += (fall === 1'b1);
            n_long += (long_press === 1'b1);
        end
    end

    initial begin
        tick(3);
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_cnt", press_cnt, 0);
        chk("rst_long", long_press, 0);
        RST = 0;
        tick(20);
        chk("idle_rises", n_rise, 0);
        chk("idle_falls", n_fall, 0);

        GPIO_IN = 0;
        tick(6);
        chk("rise_early", rise, 0);
        tick(1);
        chk("rise_edge6", rise, 1);
        chk("level_hi", level, 1);
        chk("cnt_one", press_cnt, 1);
        tick(1);
        chk("rise_one_cycle", rise, 0);
        tick(4);
        GPIO_IN = 1;
        tick(6);
        chk("fall_early", fall, 0);
        tick(1);
        chk("fall_edge6", fall, 1);
        chk("level_lo", level, 0);
        tick(1);
        chk("fall_one_cycle", fall, 0);
        tick(4);

        clr_cnt = 1;
        tick(1);
        clr_cnt = 0;
        r0 = n_rise;
        repeat (5) begin
            GPIO_IN = 0;
            tick(3);
            GPIO_IN = 1;
            tick(3);
        end
        tick(8);
        chk("bounce_rises", n_rise, r0);
        chk("bounce_level", level, 0);
        chk("bounce_cnt", press_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            GPIO_IN = 0;
            tick(7);
            chk("wrap_rise", rise, 1);
            chk("wrap_cnt", press_cnt, (i + 1) % 8);
            tick(3);
            GPIO_IN = 1;
            tick(10);
        end
        GPIO_IN = 0;
        tick(6);
        clr_cnt = 1;
        tick(1);
        clr_cnt = 0;
        chk("clr_rise", rise, 1);
        chk("clr_wins", press_cnt, 0);
        tick(3);
        GPIO_IN = 1;
        tick(10);

        GPIO_IN = 0;
        tick(4);
        RST = 1;
        tick(1);
        RST = 0;
        r0 = n_rise;
        f0 = n_fall;
        tick(6);
        chk("rstmid_no_rise", rise, 0);
        chk("rstmid_level", level, 0);
        tick(1);
        chk("rstmid_rise", rise, 1);
        tick(10);
        chk("rstmid_one_rise", n_rise, r0 + 1);
        chk("rstmid_no_fall", n_fall, f0);
        chk("rstmid_cnt", press_cnt, 1);
        GPIO_IN = 1;
        tick(10);

        l0 = n_long;
        GPIO_IN = 0;
        tick(15);
        chk("long_early", long_press, 0);
        tick(1);
        chk("long_edge15", long_press, LP);
        tick(14);
        GPIO_IN = 1;
        tick(12);
        chk("long_once", n_long, l0 + LP);
        r0 = n_rise;
        GPIO_IN = 0;
        tick(5);
        GPIO_IN = 1;
        tick(12);
        chk("short_rise", n_rise, r0 + 1);
        chk("short_no_long", n_long, l0 + LP);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
